fetch_stage: RTL and testbench

Instruction fetch stage of the processor pipeline, directly upstream of the instruction decoder. It owns the program counter, drives the synchronous instruction memory, and presents one instruction per cycle with its PC to decode. It absorbs stalls through a one-entry hold register, applies EX-stage redirects (branch, jal, jalr), and performs interrupt entry and `rti` return using a saved exception PC.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory and presents one instruction plus its PC per cycle to decode.
// Stalls are absorbed by a one-entry hold register. EX redirects, interrupt
// entry and rti return reload the fetch PC and squash the decode slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        rti,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        in_isr,
  output logic [31:0] epc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
  localparam logic [XLEN-1:0] IRQ_VEC_A  = IRQ_VECTOR & ALIGN_MASK;

  // Architectural state
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_d;
  logic            dvalid;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr;
  logic            isr_active;
  logic [XLEN-1:0] epc_q;

  // Next-state values
  logic [XLEN-1:0] pc_f_nxt;
  logic [XLEN-1:0] pc_d_nxt;
  logic            dvalid_nxt;
  logic            hold_valid_nxt;
  logic [XLEN-1:0] hold_instr_nxt;
  logic            isr_active_nxt;
  logic [XLEN-1:0] epc_nxt;

  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_f_seq;
  logic            irq_take;

  // Low address bits of the redirect target are dropped to keep fetch aligned
  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign pc_f_seq        = pc_f + INSTR_STEP;

  // Interrupt is taken only when nothing of higher priority acts this cycle
  assign irq_take = irq & ~isr_active & ~stall & ~redirect & ~rti;

  // Decode view: squash on redirect or interrupt entry, prefer held instruction
  always_comb begin
    valid_out = dvalid & ~redirect & ~irq_take;
    if (!valid_out) begin
      instr_out = NOP_INSTR;
    end else if (hold_valid) begin
      instr_out = hold_instr;
    end else begin
      instr_out = imem_rdata;
    end
  end

  assign imem_addr    = pc_f;
  assign pc_out       = pc_d;
  assign pc_plus4_out = pc_d + INSTR_STEP;
  assign in_isr       = isr_active;
  assign epc          = epc_q;

  // Next-state selection in priority order: redirect, rti, irq, stall, advance
  always_comb begin
    pc_f_nxt       = pc_f;
    pc_d_nxt       = pc_d;
    dvalid_nxt     = dvalid;
    hold_valid_nxt = hold_valid;
    hold_instr_nxt = hold_instr;
    isr_active_nxt = isr_active;
    epc_nxt        = epc_q;

    if (redirect) begin
      pc_f_nxt       = redirect_target;
      dvalid_nxt     = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (rti) begin
      pc_f_nxt       = epc_q;
      isr_active_nxt = 1'b0;
      dvalid_nxt     = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (irq_take) begin
      // Return to the squashed decode instruction, or to the fetch PC if
      // decode was already empty
      epc_nxt        = dvalid ? pc_d : pc_f;
      pc_f_nxt       = IRQ_VEC_A;
      isr_active_nxt = 1'b1;
      dvalid_nxt     = 1'b0;
      hold_valid_nxt = 1'b0;
    end else if (stall) begin
      // Capture the memory word once; the fetch address stays put so the
      // memory keeps returning the next sequential instruction
      if (!hold_valid) begin
        hold_instr_nxt = imem_rdata;
        hold_valid_nxt = 1'b1;
      end
    end else begin
      pc_d_nxt       = pc_f;
      pc_f_nxt       = pc_f_seq;
      dvalid_nxt     = 1'b1;
      hold_valid_nxt = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f       <= RESET_PC_A;
      pc_d       <= '0;
      dvalid     <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
      isr_active <= 1'b0;
      epc_q      <= '0;
    end else begin
      pc_f       <= pc_f_nxt;
      pc_d       <= pc_d_nxt;
      dvalid     <= dvalid_nxt;
      hold_valid <= hold_valid_nxt;
      hold_instr <= hold_instr_nxt;
      isr_active <= isr_active_nxt;
      epc_q      <= epc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors with literal PC/valid expectations
// plus a PC-stream model checked every cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        rti = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic        valid_out;
  logic        in_isr;
  logic [31:0] epc;

  int total = 0;
  int bad = 0;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .IRQ_VECTOR(IRQ_VECTOR),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rti         (rti),
    .irq         (irq),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .pc_plus4_out(pc_plus4_out),
    .valid_out   (valid_out),
    .in_isr      (in_isr),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  // Memory contents: identity for the low words, a distinct pattern elsewhere
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a < 32'h20) ? a : (a ^ 32'h5A5A_0000);
  endfunction

  // Synchronous instruction memory with one-cycle read latency
  always @(posedge clk) imem_rdata <= memf(imem_addr);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // Model: fetch address, decode PC/validity, ISR flag, saved PC
  logic [31:0] m_fpc, m_dpc, m_epc;
  logic        m_dv, m_isr;
  logic        started = 1'b0;

  always @(posedge clk) begin
    logic take;
    if (rst) begin
      m_fpc = RESET_PC; m_dpc = '0; m_dv = 1'b0; m_isr = 1'b0; m_epc = '0;
    end else begin
      take = irq && !m_isr && !stall && !redirect && !rti;
      if (redirect) begin
        m_fpc = {redirect_pc[31:2], 2'b00}; m_dv = 1'b0;
      end else if (rti) begin
        m_fpc = m_epc; m_isr = 1'b0; m_dv = 1'b0;
      end else if (take) begin
        m_epc = m_dv ? m_dpc : m_fpc; m_fpc = IRQ_VECTOR; m_isr = 1'b1; m_dv = 1'b0;
      end else if (!stall) begin
        m_dpc = m_fpc; m_fpc = m_fpc + 32'd4; m_dv = 1'b1;
      end
    end
    started <= 1'b1;
  end

  // Every-cycle comparison against the model; the decode instruction must
  // always be the memory word at the decode PC, whatever was stalled
  always @(negedge clk) begin
    logic take, ev;
    if (started) begin
      take = irq && !m_isr && !stall && !redirect && !rti;
      ev   = m_dv && !redirect && !take;
      chk("imem_addr", imem_addr, m_fpc);
      chk("pc_out", pc_out, m_dpc);
      chk("pc_plus4_out", pc_plus4_out, m_dpc + 32'd4);
      chk("in_isr", {31'b0, in_isr}, {31'b0, m_isr});
      chk("epc", epc, m_epc);
      if (!rti) begin
        chk("valid_out", {31'b0, valid_out}, {31'b0, ev});
        chk("instr_out", instr_out, ev ? memf(m_dpc) : NOP_INSTR);
      end
    end
  end

  always @(posedge clk)
    if (!rst) assert (!(redirect && rti)) else $error("FAIL redirect_and_rti both high");

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rdpc;
    logic        rti, irq;
    logic        ck_pc;
    logic [31:0] e_pc;
    logic        e_v;
    logic        ck_isr, e_isr;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, s, d, input logic [31:0] dp,
                              input logic t, q, cp, input logic [31:0] p,
                              input logic v, ci, ii, input logic [31:0] ep);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.rdpc = dp; x.rti = t; x.irq = q;
    x.ck_pc = cp; x.e_pc = p; x.e_v = v; x.ck_isr = ci; x.e_isr = ii; x.e_epc = ep;
    return x;
  endfunction

  initial begin
    //                 rst stl red rdpc          rti irq ckp pc            v   cki isr epc
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 1, 0, 32'h0));   // 0 reset
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 0, 32'h0));   // 1
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 0, 0, 32'h0));   // 2 first instr
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h4,        1, 0, 0, 32'h0));   // 3
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 4 stall
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 5
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 6
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 7
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'hC,        1, 0, 0, 32'h0));   // 8
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h10,       0, 1, 0, 32'h0));   // 9 irq
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h10,       0, 1, 1, 32'h10));  // 10
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h1000,     1, 1, 1, 32'h10));  // 11 masked irq
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h1004,     1, 1, 1, 32'h10));  // 12
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 32'h0));   // 13 rti
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h1008,     0, 1, 0, 32'h10));  // 14
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h10,       1, 0, 0, 32'h0));   // 15 return
    vecs.push_back(mk(0, 0, 1, 32'h8,        0, 0, 1, 32'h14,       0, 0, 0, 32'h0));   // 16
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h14,       0, 0, 0, 32'h0));   // 17
    vecs.push_back(mk(0, 0, 1, 32'h203,      0, 0, 1, 32'h8,        0, 0, 0, 32'h0));   // 18 redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h8,        0, 0, 0, 32'h0));   // 19
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 1, 32'h200,      1, 1, 0, 32'h10));  // 20 irq+stall
    vecs.push_back(mk(0, 0, 1, 32'h40,       0, 1, 1, 32'h200,      0, 1, 0, 32'h10));  // 21 irq+redirect
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 1, 32'h200,      0, 1, 0, 32'h10));  // 22 irq taken
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h200,      0, 1, 1, 32'h40));  // 23
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 0, 0, 32'h0));   // 24 rti
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h1000,     0, 1, 0, 32'h40));  // 25
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h40,       1, 0, 0, 32'h0));   // 26
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,0, 0, 1, 32'h44,       0, 0, 0, 32'h0));   // 27
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h44,       0, 0, 0, 32'h0));   // 28
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'hFFFF_FFFC,1, 0, 0, 32'h0));   // 29 top of space
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 0, 0, 32'h0));   // 30 wrapped
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h4,        1, 0, 0, 32'h0));   // 31
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 32 stall
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 32'h8,        1, 0, 0, 32'h0));   // 33 reset mid-stall
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 1, 0, 32'h0));   // 34 reset values
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        0, 0, 0, 32'h0));   // 35
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 0, 0, 32'h0));   // 36
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 1, 32'h4,        1, 0, 0, 32'h0));   // 37 stall
    vecs.push_back(mk(0, 1, 1, 32'h100,      0, 0, 1, 32'h4,        0, 0, 0, 32'h0));   // 38 redirect in stall
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h4,        0, 0, 0, 32'h0));   // 39
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h100,      1, 0, 0, 32'h0));   // 40
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 32'h104,      1, 0, 0, 32'h0));   // 41

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rdpc; rti = vecs[i].rti; irq = vecs[i].irq;
      @(negedge clk);
      if (vecs[i].ck_pc) begin
        chk($sformatf("lit_pc[%0d]", i), pc_out, vecs[i].e_pc);
        chk($sformatf("lit_valid[%0d]", i), {31'b0, valid_out}, {31'b0, vecs[i].e_v});
        chk($sformatf("lit_instr[%0d]", i), instr_out,
            vecs[i].e_v ? memf(vecs[i].e_pc) : NOP_INSTR);
      end
      if (vecs[i].ck_isr) begin
        chk($sformatf("lit_isr[%0d]", i), {31'b0, in_isr}, {31'b0, vecs[i].e_isr});
        chk($sformatf("lit_epc[%0d]", i), epc, vecs[i].e_epc);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; rti = 1'b0; irq = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
